// File: rtl/object_bank.sv
// Object record store: one write port, one read port, 4-lane batched reads with zero-fill after reset.
// Latency: a batch of n set lanes pulses is_valid_out n+2 cycles after it is accepted.
// Backpressure: read requests are taken only while busy_out=0; requests made while busy are dropped, not queued.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   write_valid_in + fields  one record write per cycle at save_addr_in
//   read_valid_in, load_addr_in  lane request mask and per-lane read addresses
//   *_out                    per-lane record fields, is_valid_out completion pulse, busy_out
module object_bank #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   write_valid_in,
    input  logic [ADDR_W-1:0]      save_addr_in,
    input  logic                   is_static_in,
    input  logic [1:0]             id_bits_in,
    input  logic [35:0]            params_in,
    input  logic [15:0]            pos_x_in,
    input  logic [15:0]            pos_y_in,
    input  logic [15:0]            vel_x_in,
    input  logic [15:0]            vel_y_in,
    input  logic [3:0]             read_valid_in,
    input  logic [3:0][ADDR_W-1:0] load_addr_in,
    output logic [3:0]             is_static_out,
    output logic [3:0][1:0]        id_bits_out,
    output logic [3:0][35:0]       params_out,
    output logic [3:0][15:0]       pos_x_out,
    output logic [3:0][15:0]       pos_y_out,
    output logic [3:0][15:0]       vel_x_out,
    output logic [3:0][15:0]       vel_y_out,
    output logic [3:0]             is_valid_out,
    output logic                   busy_out
);

    // Record layout, MSB first; 103 bits in total.
    typedef struct packed {
        logic        is_static;
        logic [1:0]  id_bits;
        logic [35:0] params;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] vel_x;
        logic [15:0] vel_y;
    } obj_rec_t;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // One extra bit so the range compare also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]             state;
    logic [ADDR_W-1:0]      fill;
    logic [3:0]             mask_q;
    logic [3:0]             pend_q;
    logic [3:0][ADDR_W-1:0] addr_q;

    // ------------------------------------------------------------------
    // Lane issue: the lowest still-pending lane goes out this cycle.
    // ------------------------------------------------------------------
    logic [1:0] sel_lane;
    logic [3:0] pend_nxt;

    always_comb begin
        sel_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_lane = 2'(i);
            end
        end
        pend_nxt           = pend_q;
        pend_nxt[sel_lane] = 1'b0;
    end

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_oor;
    logic [IDX_W-1:0]  rd_idx;

    assign rd_addr = addr_q[sel_lane];
    assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_W);
    // Out-of-range reads alias onto a real entry; the oor flag zeroes the result later.
    assign rd_idx  = rd_addr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Write port: owned by the zero-fill in INIT, otherwise by the saver.
    // ------------------------------------------------------------------
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    obj_rec_t          wr_dat;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = save_addr_in[IDX_W-1:0];
        wr_dat = {is_static_in, id_bits_in, params_in,
                  pos_x_in, pos_y_in, vel_x_in, vel_y_in};
        if (state == ST_INIT) begin
            wr_en  = 1'b1;
            wr_idx = fill[IDX_W-1:0];
            wr_dat = '0;
        end else begin
            wr_en = write_valid_in && ({1'b0, save_addr_in} < DEPTH_W);
        end
    end

    // ------------------------------------------------------------------
    // Storage. Read and write share one edge with non-blocking updates,
    // so a same-cycle read of a written address sees the old word.
    // ------------------------------------------------------------------
    obj_rec_t mem [DEPTH];
    obj_rec_t rd_q;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
        rd_q <= mem[rd_idx];
    end

    // Tag travelling alongside rd_q: which lane it belongs to and whether
    // the address was out of range.
    logic       s1_vld;
    logic       s1_oor;
    logic [1:0] s1_lane;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_vld  <= 1'b0;
            s1_oor  <= 1'b0;
            s1_lane <= 2'd0;
        end else begin
            s1_vld  <= (state == ST_ISSUE);
            s1_oor  <= rd_oor;
            s1_lane <= sel_lane;
        end
    end

    // Lane output registers: the second read stage. Unselected lanes hold.
    obj_rec_t [3:0] lane_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lane_q <= '0;
        end else if (s1_vld) begin
            lane_q[s1_lane] <= s1_oor ? obj_rec_t'('0) : rd_q;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= ST_INIT;
            fill         <= '0;
            mask_q       <= 4'b0;
            pend_q       <= 4'b0;
            addr_q       <= '0;
            is_valid_out <= 4'b0;
        end else begin
            is_valid_out <= 4'b0;
            case (state)
                ST_INIT: begin
                    fill <= fill + 1'b1;
                    if (fill == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (read_valid_in != 4'b0) begin
                        mask_q <= read_valid_in;
                        pend_q <= read_valid_in;
                        addr_q <= load_addr_in;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    pend_q <= pend_nxt;
                    if (pend_nxt == 4'b0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last lane lands in lane_q on this same edge.
                    is_valid_out <= mask_q;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign busy_out = (state != ST_IDLE);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign is_static_out[k] = lane_q[k].is_static;
        assign id_bits_out[k]   = lane_q[k].id_bits;
        assign params_out[k]    = lane_q[k].params;
        assign pos_x_out[k]     = lane_q[k].pos_x;
        assign pos_y_out[k]     = lane_q[k].pos_y;
        assign vel_x_out[k]     = lane_q[k].vel_x;
        assign vel_y_out[k]     = lane_q[k].vel_y;
    end

endmodule

// File: tb/tb_object_bank.sv
// Directed bench for object_bank: fill timing, batches, sparse masks, collisions, abort, range.
// Latency: checks busy/valid cycle by cycle against the n+2 batch timing.
// Backpressure: holds requests during busy and expects them to be dropped.
module tb_object_bank;

    typedef struct packed {
        logic        is_static;
        logic [1:0]  id_bits;
        logic [35:0] params;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] vel_x;
        logic [15:0] vel_y;
    } rec_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic             sys_rst;
    logic             write_valid_in;
    logic [6:0]       save_addr_in;
    logic             is_static_in;
    logic [1:0]       id_bits_in;
    logic [35:0]      params_in;
    logic [15:0]      pos_x_in, pos_y_in, vel_x_in, vel_y_in;
    logic [3:0]       read_valid_in;
    logic [3:0][6:0]  load_addr_in;

    logic [3:0]        is_static_out, is_static_out_b;
    logic [3:0][1:0]   id_bits_out, id_bits_out_b;
    logic [3:0][35:0]  params_out, params_out_b;
    logic [3:0][15:0]  pos_x_out, pos_x_out_b, pos_y_out, pos_y_out_b;
    logic [3:0][15:0]  vel_x_out, vel_x_out_b, vel_y_out, vel_y_out_b;
    logic [3:0]        is_valid_out, is_valid_out_b;
    logic              busy_out, busy_out_b;

    object_bank #(.DEPTH(128), .ADDR_W(7)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .write_valid_in(write_valid_in), .save_addr_in(save_addr_in),
        .is_static_in(is_static_in), .id_bits_in(id_bits_in), .params_in(params_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .read_valid_in(read_valid_in), .load_addr_in(load_addr_in),
        .is_static_out(is_static_out), .id_bits_out(id_bits_out), .params_out(params_out),
        .pos_x_out(pos_x_out), .pos_y_out(pos_y_out), .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
        .is_valid_out(is_valid_out), .busy_out(busy_out)
    );

    object_bank #(.DEPTH(64), .ADDR_W(7)) dut64 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .write_valid_in(write_valid_in), .save_addr_in(save_addr_in),
        .is_static_in(is_static_in), .id_bits_in(id_bits_in), .params_in(params_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .read_valid_in(read_valid_in), .load_addr_in(load_addr_in),
        .is_static_out(is_static_out_b), .id_bits_out(id_bits_out_b), .params_out(params_out_b),
        .pos_x_out(pos_x_out_b), .pos_y_out(pos_y_out_b), .vel_x_out(vel_x_out_b), .vel_y_out(vel_y_out_b),
        .is_valid_out(is_valid_out_b), .busy_out(busy_out_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    function automatic rec_t mk_rec(input int a);
        rec_t r;
        logic [31:0] v;
        v           = a;
        r.is_static = v[0];
        r.id_bits   = v[2:1];
        r.params    = 36'(v) * 36'd4097;
        r.pos_x     = 16'(v * 3);
        r.pos_y     = v[15:0] + 16'd100;
        r.vel_x     = 16'hBEEF ^ v[15:0];
        r.vel_y     = 16'h0A00 + v[15:0];
        return r;
    endfunction

    function automatic rec_t lane_a(input int k);
        lane_a = {is_static_out[k], id_bits_out[k], params_out[k],
                  pos_x_out[k], pos_y_out[k], vel_x_out[k], vel_y_out[k]};
    endfunction

    function automatic rec_t lane_b(input int k);
        lane_b = {is_static_out_b[k], id_bits_out_b[k], params_out_b[k],
                  pos_x_out_b[k], pos_y_out_b[k], vel_x_out_b[k], vel_y_out_b[k]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [6:0] a, input rec_t r);
        write_valid_in = en;
        save_addr_in   = a;
        {is_static_in, id_bits_in, params_in, pos_x_in, pos_y_in, vel_x_in, vel_y_in} = r;
    endtask

    // Runs one batch from its accept cycle (0) to the valid pulse (n+2).
    // Optionally holds the request during busy and injects one write in cycle wr_cyc.
    task automatic do_batch(input string tag, input logic [3:0] mask, input logic [3:0][6:0] addrs,
                            input logic hold, input int wr_cyc, input logic [6:0] wa, input rec_t wr);
        int n;
        n             = $countones(mask);
        read_valid_in = mask;
        load_addr_in  = addrs;
        set_wr(wr_cyc == 0, wa, wr);
        for (int c = 1; c <= n + 2; c++) begin
            tick();
            read_valid_in = (hold && c <= n + 1) ? mask : 4'b0;
            set_wr(c == wr_cyc, wa, wr);
            if (c <= n + 1) begin
                chk({tag, " busy"}, 128'(busy_out), 128'd1);
                chk({tag, " early valid"}, 128'(is_valid_out), 128'd0);
            end else begin
                chk({tag, " valid"}, 128'(is_valid_out), 128'(mask));
                chk({tag, " busy done"}, 128'(busy_out), 128'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   cnt, cnt64, seen;
        rec_t newr;

        sys_rst       = 1'b1;
        read_valid_in = 4'b0;
        load_addr_in  = '0;
        set_wr(1'b0, 7'd0, '0);
        repeat (3) tick();

        // Reset state
        chk("rst valid", 128'(is_valid_out), 128'd0);
        chk("rst busy", 128'(busy_out), 128'd1);
        for (int k = 0; k < 4; k++) chk("rst lane", 128'(lane_a(k)), 128'd0);

        // Fill timing for both depths
        sys_rst = 1'b0;
        cnt     = 0;
        cnt64   = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cnt++;
            if (!busy_out_b && cnt64 == 0) cnt64 = cnt;
            if (!busy_out) break;
        end
        chk("fill cycles 128", 128'(cnt), 128'd128);
        chk("fill cycles 64", 128'(cnt64), 128'd64);

        // Zero-filled contents
        do_batch("zero", 4'b1111, {7'd127, 7'd2, 7'd1, 7'd0}, 1'b0, -1, 7'd0, '0);
        for (int k = 0; k < 4; k++) chk("zero lane", 128'(lane_a(k)), 128'd0);

        // Load records 0..11
        for (int a = 0; a < 12; a++) begin
            set_wr(1'b1, 7'(a), mk_rec(a));
            tick();
        end
        set_wr(1'b0, 7'd0, '0);

        // Full batch
        do_batch("full", 4'b1111, {7'd7, 7'd6, 7'd5, 7'd4}, 1'b0, -1, 7'd0, '0);
        for (int k = 0; k < 4; k++) begin
            chk("full pos_x", 128'(pos_x_out[k]), 128'((4 + k) * 3));
            chk("full rec", 128'(lane_a(k)), 128'(mk_rec(4 + k)));
        end
        tick();
        chk("full pulse width", 128'(is_valid_out), 128'd0);

        // Sparse mask keeps lanes 0 and 2
        set_wr(1'b1, 7'd20, rec_t'(103'h55));
        tick();
        set_wr(1'b0, 7'd0, '0);
        do_batch("preload", 4'b1111, {7'd0, 7'd20, 7'd0, 7'd20}, 1'b0, -1, 7'd0, '0);
        do_batch("sparse", 4'b1010, {7'd11, 7'd0, 7'd9, 7'd0}, 1'b0, -1, 7'd0, '0);
        chk("sparse lane0 held", 128'(lane_a(0)), 128'h55);
        chk("sparse lane2 held", 128'(lane_a(2)), 128'h55);
        chk("sparse lane1", 128'(lane_a(1)), 128'(mk_rec(9)));
        chk("sparse lane3", 128'(lane_a(3)), 128'(mk_rec(11)));

        // Read/write collision on address 3 during lane 1 issue (cycle 2)
        newr       = mk_rec(3);
        newr.vel_y = 16'h1234;
        do_batch("coll", 4'b1111, {7'd3, 7'd3, 7'd3, 7'd3}, 1'b0, 2, 7'd3, newr);
        chk("coll lane0 old", 128'(vel_y_out[0]), 128'h0A03);
        chk("coll lane1 old", 128'(vel_y_out[1]), 128'h0A03);
        chk("coll lane2 new", 128'(vel_y_out[2]), 128'h1234);
        chk("coll lane3 new", 128'(vel_y_out[3]), 128'h1234);

        // Request held while busy is dropped
        do_batch("hold", 4'b0011, {7'd0, 7'd0, 7'd1, 7'd0}, 1'b1, -1, 7'd0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold no second pulse", 128'(is_valid_out), 128'd0);
            chk("hold no second batch", 128'(busy_out), 128'd0);
        end

        // Reset in cycle 2 of a batch
        read_valid_in = 4'b1111;
        load_addr_in  = {7'd7, 7'd6, 7'd5, 7'd4};
        tick();
        read_valid_in = 4'b0;
        tick();
        sys_rst = 1'b1;
        #1;
        chk("abort valid", 128'(is_valid_out), 128'd0);
        chk("abort busy", 128'(busy_out), 128'd1);
        for (int k = 0; k < 4; k++) chk("abort lane", 128'(lane_a(k)), 128'd0);
        tick();
        tick();
        sys_rst = 1'b0;
        cnt     = 0;
        seen    = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cnt++;
            if (is_valid_out != 4'b0) seen++;
            if (!busy_out) break;
        end
        chk("refill cycles", 128'(cnt), 128'd128);
        chk("abort no pulse", 128'(seen), 128'd0);

        // Range and duplicates on the 64-deep instance
        set_wr(1'b1, 7'd70, mk_rec(70));
        tick();
        set_wr(1'b1, 7'd63, mk_rec(63));
        tick();
        set_wr(1'b1, 7'd0, mk_rec(0));
        tick();
        set_wr(1'b0, 7'd0, '0);
        do_batch("range", 4'b1111, {7'd63, 7'd0, 7'd0, 7'd70}, 1'b0, -1, 7'd0, '0);
        chk("range d64 valid", 128'(is_valid_out_b), 128'hF);
        chk("range d64 lane0 zero", 128'(lane_b(0)), 128'd0);
        chk("range d64 lane1", 128'(lane_b(1)), 128'(mk_rec(0)));
        chk("range d64 lane2", 128'(lane_b(2)), 128'(mk_rec(0)));
        chk("range d64 dup equal", 128'(lane_b(2)), 128'(lane_b(1)));
        chk("range d64 lane3", 128'(lane_b(3)), 128'(mk_rec(63)));
        chk("range d128 lane0", 128'(lane_a(0)), 128'(mk_rec(70)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
